// File: rtl/wb_line_master.sv
// Word-to-line Wishbone classic master adapter: one registered bus cycle per CPU request.
// Optional one-line read buffer enabled by defining WB_LINE_BUFFER_EN.
module wb_line_master #(
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         cpu_req,
   input  logic                                         cpu_we,
   input  logic [ADDR_WIDTH-1:0]                        cpu_addr,
   input  logic [WORD_WIDTH/8-1:0]                      cpu_be,
   input  logic [WORD_WIDTH-1:0]                        cpu_wdata,
   output logic [WORD_WIDTH-1:0]                        cpu_rdata,
   output logic                                         cpu_resp,
   input  logic                                         buf_inv,
   output logic [ADDR_WIDTH-$clog2(LINE_WIDTH/8)-1:0]   wb_adr,
   output logic [LINE_WIDTH-1:0]                        wb_dat_m,
   input  logic [LINE_WIDTH-1:0]                        wb_dat_s,
   output logic [LINE_WIDTH/8-1:0]                      wb_sel,
   output logic                                         wb_we,
   output logic                                         wb_stb,
   output logic                                         wb_cyc,
   input  logic                                         wb_ack
);

   localparam int unsigned WB    = WORD_WIDTH / 8;
   localparam int unsigned LB    = LINE_WIDTH / 8;
   localparam int unsigned WOFF  = $clog2(WB);
   localparam int unsigned LOFF  = $clog2(LB);
   localparam int unsigned IDXW  = LOFF - WOFF;
   localparam int unsigned TAGW  = ADDR_WIDTH - LOFF;
   localparam int unsigned NLANE = LINE_WIDTH / WORD_WIDTH;

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;

   state_e                state_q, state_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic [TAGW-1:0]       adr_q, adr_d;
   logic [LB-1:0]         sel_q, sel_d;
   logic [LINE_WIDTH-1:0] dat_q, dat_d;
   logic                  we_q, we_d;
   logic                  stb_q, stb_d;
   logic                  resp_q, resp_d;
   logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

   logic [IDXW-1:0]       req_idx_c;
   logic [TAGW-1:0]       req_tag_c;
   logic [LB-1:0]         rd_sel_c, wr_sel_c;
   logic                  unused_c;

   assign req_idx_c = cpu_addr[LOFF-1:WOFF];
   assign req_tag_c = cpu_addr[ADDR_WIDTH-1:LOFF];
   assign rd_sel_c  = LB'({WB{1'b1}}) << (32'(req_idx_c) * WB);
   assign wr_sel_c  = LB'(cpu_be) << (32'(req_idx_c) * WB);
   // Sub-word address bits carry no information for a word-sized port.
   assign unused_c  = ^{cpu_addr, buf_inv};

`ifdef WB_LINE_BUFFER_EN
   logic [LINE_WIDTH-1:0] buf_dat_q, buf_dat_d;
   logic [TAGW-1:0]       buf_tag_q, buf_tag_d;
   logic                  buf_vld_q, buf_vld_d;
   logic                  hit_c;

   assign hit_c = buf_vld_q && !buf_inv && (buf_tag_q == req_tag_c);
`endif

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      dat_d   = dat_q;
      we_d    = we_q;
      stb_d   = stb_q;
      resp_d  = 1'b0;
      rdata_d = rdata_q;
`ifdef WB_LINE_BUFFER_EN
      buf_dat_d = buf_dat_q;
      buf_tag_d = buf_tag_q;
      buf_vld_d = buf_vld_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cpu_req) begin
               idx_d = req_idx_c;
               if (cpu_we && (cpu_be == '0)) begin
                  state_d = DONE;
                  resp_d  = 1'b1;
               end
`ifdef WB_LINE_BUFFER_EN
               else if (!cpu_we && hit_c) begin
                  state_d = DONE;
                  resp_d  = 1'b1;
                  rdata_d = buf_dat_q[32'(req_idx_c) * WORD_WIDTH +: WORD_WIDTH];
               end
`endif
               else begin
                  state_d = BUS;
                  stb_d   = 1'b1;
                  we_d    = cpu_we;
                  adr_d   = req_tag_c;
                  sel_d   = cpu_we ? wr_sel_c : rd_sel_c;
                  if (cpu_we) dat_d = {NLANE{cpu_wdata}};
               end
            end
         end
         BUS: begin
            if (wb_ack) begin
               state_d = DONE;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               resp_d  = 1'b1;
               if (!we_q) rdata_d = wb_dat_s[32'(idx_q) * WORD_WIDTH +: WORD_WIDTH];
`ifdef WB_LINE_BUFFER_EN
               if (!we_q) begin
                  buf_dat_d = wb_dat_s;
                  buf_tag_d = adr_q;
                  buf_vld_d = 1'b1;
               end else if (buf_vld_q && (buf_tag_q == adr_q)) begin
                  for (int unsigned b = 0; b < LB; b++)
                     if (sel_q[b]) buf_dat_d[b*8 +: 8] = dat_q[b*8 +: 8];
               end
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef WB_LINE_BUFFER_EN
      if (buf_inv) buf_vld_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         adr_q   <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         stb_q   <= 1'b0;
         resp_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         stb_q   <= stb_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef WB_LINE_BUFFER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_dat_q <= '0;
         buf_tag_q <= '0;
         buf_vld_q <= 1'b0;
      end else begin
         buf_dat_q <= buf_dat_d;
         buf_tag_q <= buf_tag_d;
         buf_vld_q <= buf_vld_d;
      end
   end
`endif

   assign wb_adr    = adr_q;
   assign wb_sel    = sel_q;
   assign wb_dat_m  = dat_q;
   assign wb_we     = we_q;
   assign wb_stb    = stb_q;
   assign wb_cyc    = stb_q;
   assign cpu_resp  = resp_q;
   assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_wb_line_master.sv
// Scoreboard bench for wb_line_master: expected read words queued per request, checked on cpu_resp.
module tb_wb_line_master;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cpu_req, cpu_we, buf_inv, wb_ack;
   logic [15:0]  cpu_addr, cpu_wdata, cpu_rdata;
   logic [1:0]   cpu_be;
   logic         cpu_resp;
   logic [11:0]  wb_adr;
   logic [127:0] wb_dat_m, wb_dat_s;
   logic [15:0]  wb_sel;
   logic         wb_we, wb_stb, wb_cyc;

   int errs = 0;
   int checks = 0;
   int stb_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] last_rd;

   wb_line_master dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp),
      .buf_inv(buf_inv), .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s),
      .wb_sel(wb_sel), .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) if (wb_stb) stb_cnt <= stb_cnt + 1;

   // Every response consumes one expected read word.
   always @(negedge clk) begin
      if (cpu_resp) begin
         if (exp_q.size() == 0) check("resp_unexpected", 128'(1), 128'(0));
         else check("rdata", 128'(cpu_rdata), 128'(exp_q.pop_front()));
      end
   end

   task automatic do_req(input logic we, input logic [15:0] addr, input logic [1:0] be,
                         input logic [15:0] wd, input int dly, input logic [127:0] line,
                         input logic bus, input logic [15:0] exp_sel, input logic [15:0] exp_rd);
      logic [11:0] exp_adr;
      exp_adr = addr[15:4];
      exp_q.push_back(exp_rd);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
      @(posedge clk);
      if (bus) begin
         for (int i = 0; i <= dly; i++) begin
            @(negedge clk);
            check("stb", 128'(wb_stb), 128'(1));
            check("cyc", 128'(wb_cyc), 128'(1));
            check("we", 128'(wb_we), 128'(we));
            check("adr", 128'(wb_adr), 128'(exp_adr));
            check("sel", 128'(wb_sel), 128'(exp_sel));
            if (we) check("dat_m", wb_dat_m, {8{wd}});
            check("resp_early", 128'(cpu_resp), 128'(0));
            if (i == dly) begin
               wb_ack = 1'b1;
               wb_dat_s = line;
            end
            @(posedge clk);
         end
         #1;
         wb_ack = 1'b0; wb_dat_s = '0; cpu_req = 1'b0;
         @(negedge clk);
         check("resp", 128'(cpu_resp), 128'(1));
         check("stb_drop", 128'(wb_stb), 128'(0));
         check("cyc_drop", 128'(wb_cyc), 128'(0));
         check("we_drop", 128'(wb_we), 128'(0));
      end else begin
         #1 cpu_req = 1'b0;
         @(negedge clk);
         check("resp_nobus", 128'(cpu_resp), 128'(1));
         check("no_stb", 128'(wb_stb), 128'(0));
      end
      @(posedge clk);
      @(negedge clk);
      check("resp_pulse", 128'(cpu_resp), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] ln;
      logic [15:0]  a;
      logic [2:0]   idx;
      int           sc;

      rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0;
      cpu_wdata = '0; buf_inv = 1'b0; wb_ack = 1'b0; wb_dat_s = '0;
      last_rd = '0;
      #12;
      check("rst_stb", 128'(wb_stb), 128'(0));
      check("rst_cyc", 128'(wb_cyc), 128'(0));
      check("rst_we", 128'(wb_we), 128'(0));
      check("rst_resp", 128'(cpu_resp), 128'(0));
      check("rst_adr", 128'(wb_adr), 128'(0));
      check("rst_sel", 128'(wb_sel), 128'(0));
      check("rst_dat_m", wb_dat_m, 128'(0));
      check("rst_rdata", 128'(cpu_rdata), 128'(0));
      @(negedge clk) rst_n = 1'b1;

      // Read 0x1236, immediate ack, lane 3 = BEEF.
      for (int i = 0; i < 8; i++) ln[i*16 +: 16] = 16'h1000 + 16'(i);
      ln[3*16 +: 16] = 16'hBEEF;
      do_req(1'b0, 16'h1236, 2'b00, 16'h0, 0, ln, 1'b1, 16'h00C0, 16'hBEEF);
      last_rd = 16'hBEEF;

      // Write 0x004E, upper byte only; rdata must keep BEEF.
      do_req(1'b1, 16'h004E, 2'b10, 16'hA55A, 0, '0, 1'b1, 16'h8000, last_rd);

      // Read with a 5-cycle ack delay.
      for (int i = 0; i < 8; i++) ln[i*16 +: 16] = 16'h5000 + 16'(i);
      do_req(1'b0, 16'h0002, 2'b00, 16'h0, 5, ln, 1'b1, 16'h000C, 16'h5001);
      last_rd = 16'h5001;

      // Stray ack while idle.
      @(posedge clk); #1 wb_ack = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("stray_ack_resp", 128'(cpu_resp), 128'(0));
      check("stray_ack_stb", 128'(wb_stb), 128'(0));
      wb_ack = 1'b0;

      // Write with be=0, request held through DONE.
      sc = stb_cnt;
      exp_q.push_back(last_rd);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_be = 2'b00; cpu_wdata = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      check("be0_resp", 128'(cpu_resp), 128'(1));
      check("be0_stb", 128'(wb_stb), 128'(0));
      @(posedge clk);
      @(negedge clk);
      check("be0_no_reaccept", 128'(cpu_resp), 128'(0));
      cpu_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("be0_idle_resp", 128'(cpu_resp), 128'(0));
      check("be0_stb_count", 128'(stb_cnt), 128'(sc));

      // Reset in the middle of a bus cycle.
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
      @(posedge clk);
      @(negedge clk);
      check("pre_rst_stb", 128'(wb_stb), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_stb", 128'(wb_stb), 128'(0));
      check("async_rst_cyc", 128'(wb_cyc), 128'(0));
      check("async_rst_resp", 128'(cpu_resp), 128'(0));
      cpu_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; wb_ack = 1'b1;
      @(posedge clk); #1 wb_ack = 1'b0;
      @(negedge clk);
      check("late_ack_resp", 128'(cpu_resp), 128'(0));
      check("late_ack_stb", 128'(wb_stb), 128'(0));
      last_rd = '0;

      // Random reads, distinct line tags.
      for (int i = 0; i < 4; i++) begin
         ln = {$urandom, $urandom, $urandom, $urandom};
         a = 16'h2000 | 16'(i << 4) | 16'($urandom_range(0, 15));
         idx = a[3:1];
         do_req(1'b0, a, 2'b00, 16'h0, int'($urandom_range(0, 2)), ln, 1'b1,
                16'h0003 << (32'(idx) * 2), ln[32'(idx)*16 +: 16]);
         last_rd = ln[32'(idx)*16 +: 16];
      end

      for (int i = 0; i < 8; i++) ln[i*16 +: 16] = 16'h7700 + 16'(i);
      do_req(1'b0, 16'h1236, 2'b00, 16'h0, 0, ln, 1'b1, 16'h00C0, 16'h7703);
      last_rd = 16'h7703;
`ifdef WB_LINE_BUFFER_EN
      sc = stb_cnt;
      do_req(1'b0, 16'h1230, 2'b00, 16'h0, 0, '0, 1'b0, 16'h0, 16'h7700);
      check("hit_no_stb", 128'(stb_cnt), 128'(sc));
      last_rd = 16'h7700;
      do_req(1'b1, 16'h1230, 2'b11, 16'h1111, 0, '0, 1'b1, 16'h0003, last_rd);
      sc = stb_cnt;
      do_req(1'b0, 16'h1230, 2'b00, 16'h0, 0, '0, 1'b0, 16'h0, 16'h1111);
      check("merge_no_stb", 128'(stb_cnt), 128'(sc));
      @(posedge clk); #1 buf_inv = 1'b1;
      @(posedge clk); #1 buf_inv = 1'b0;
      ln[15:0] = 16'h2222;
      do_req(1'b0, 16'h1230, 2'b00, 16'h0, 1, ln, 1'b1, 16'h0003, 16'h2222);
`else
      // Without the buffer a repeated read of the same line still uses the bus.
      @(posedge clk); #1 buf_inv = 1'b1;
      @(posedge clk); #1 buf_inv = 1'b0;
      ln[15:0] = 16'h3333;
      do_req(1'b0, 16'h1230, 2'b00, 16'h0, 1, ln, 1'b1, 16'h0003, 16'h3333);
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
